// File: rtl/nonce_scheduler_if.sv
// -----------------------------------------------------------------------------
// nonce_scheduler_if
// Bundles the job-control and hash-core dispatch signals of nonce_scheduler.
//   master : job host and hash cores (drive start/abort/range and core status)
//   slave  : the scheduler itself (drives dispatch requests and job status)
// Signals:
//   start, abort            job control pulses
//   nonce_base, nonce_limit inclusive nonce range of a job
//   core_req, core_nonce    one-hot dispatch offer and the offered nonce
//   core_ack                per-core acceptance of the offer
//   core_done, core_hit     per-core completion pulse and target-met flag
//   core_result             per-core completed nonce, core i at [i*NONCE_W +: NONCE_W]
//   busy, found, found_nonce, exhausted   job status
// -----------------------------------------------------------------------------
interface nonce_scheduler_if #(
  parameter int CORES   = 2,
  parameter int NONCE_W = 32
);
  logic                     start;
  logic                     abort;
  logic [NONCE_W-1:0]       nonce_base;
  logic [NONCE_W-1:0]       nonce_limit;
  logic [CORES-1:0]         core_req;
  logic [NONCE_W-1:0]       core_nonce;
  logic [CORES-1:0]         core_ack;
  logic [CORES-1:0]         core_done;
  logic [CORES-1:0]         core_hit;
  logic [CORES*NONCE_W-1:0] core_result;
  logic                     busy;
  logic                     found;
  logic [NONCE_W-1:0]       found_nonce;
  logic                     exhausted;

  modport master (
    output start, abort, nonce_base, nonce_limit,
    output core_ack, core_done, core_hit, core_result,
    input  core_req, core_nonce, busy, found, found_nonce, exhausted
  );

  modport slave (
    input  start, abort, nonce_base, nonce_limit,
    input  core_ack, core_done, core_hit, core_result,
    output core_req, core_nonce, busy, found, found_nonce, exhausted
  );
endinterface

// File: rtl/nonce_scheduler.sv
// -----------------------------------------------------------------------------
// nonce_scheduler
// Hands out the nonces of an inclusive range [nonce_base, nonce_limit] to a
// pool of hash cores, one nonce per handshake, round-robin over free cores,
// and reports either the first winning nonce or exhaustion of the range.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset, overrides everything
//   bus    nonce_scheduler_if.slave (job control, core dispatch, status)
// -----------------------------------------------------------------------------
module nonce_scheduler #(
  parameter int CORES   = 2,
  parameter int NONCE_W = 32
) (
  input logic              clk,
  input logic              reset,
  nonce_scheduler_if.slave bus
);

  localparam int PTR_W = (CORES > 1) ? $clog2(CORES) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  // Grants the first free core at or after ptr (wrapping); rotate so ptr is
  // bit 0, isolate the lowest set bit, rotate back.
  function automatic logic [CORES-1:0] rr_pick(input logic [CORES-1:0] free,
                                               input logic [PTR_W-1:0] ptr);
    logic [2*CORES-1:0] dbl;
    logic [CORES-1:0]   rot;
    logic [CORES-1:0]   low;
    dbl = {free, free} >> ptr;
    rot = dbl[CORES-1:0];
    low = rot & (~rot + {{(CORES-1){1'b0}}, 1'b1});
    dbl = {low, low} << ptr;
    return dbl[2*CORES-1:CORES];
  endfunction

  // Index of the lowest set bit (0 when none is set).
  function automatic logic [PTR_W-1:0] lowest_idx(input logic [CORES-1:0] vec);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int k = CORES - 1; k >= 0; k--) begin
      if (vec[k]) idx = PTR_W'(k);
    end
    return idx;
  endfunction

  state_t             state_q;
  logic [NONCE_W-1:0] nonce_q;
  logic [NONCE_W-1:0] limit_q;
  logic [CORES-1:0]   occ_q;
  logic [PTR_W-1:0]   rr_q;
  logic               reportable_q;
  logic [CORES-1:0]   core_req_q;
  logic [NONCE_W-1:0] core_nonce_q;
  logic               found_q;
  logic [NONCE_W-1:0] found_nonce_q;
  logic               exhausted_q;
  logic               busy_q;

  logic [CORES-1:0]   accept_s;
  logic [CORES-1:0]   occ_d;
  logic [CORES-1:0]   hit_s;
  logic [PTR_W-1:0]   acc_idx_s;
  logic [PTR_W-1:0]   hit_idx_s;
  logic [PTR_W-1:0]   rr_d;
  logic [NONCE_W-1:0] nonce_inc_s;
  logic [NONCE_W-1:0] hit_res_s;

  // Handshake decode: acceptances, next occupancy, qualified hits, next pointer.
  always_comb begin
    accept_s    = core_req_q & bus.core_ack;
    occ_d       = (occ_q & ~bus.core_done) | accept_s;
    // Only occupied cores may report; done from an idle core is noise.
    hit_s       = bus.core_done & bus.core_hit & occ_q;
    acc_idx_s   = lowest_idx(accept_s);
    hit_idx_s   = lowest_idx(hit_s);
    hit_res_s   = bus.core_result[hit_idx_s*NONCE_W +: NONCE_W];
    nonce_inc_s = nonce_q + {{(NONCE_W-1){1'b0}}, 1'b1};
    if (|accept_s) begin
      rr_d = PTR_W'((int'(acc_idx_s) + 1) % CORES);
    end else begin
      rr_d = rr_q;
    end
  end

  // Job FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      nonce_q       <= '0;
      limit_q       <= '0;
      occ_q         <= '0;
      rr_q          <= '0;
      reportable_q  <= 1'b0;
      core_req_q    <= '0;
      core_nonce_q  <= '0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      exhausted_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      rr_q        <= rr_d;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_q      <= DISPATCH;
            nonce_q      <= bus.nonce_base;
            limit_q      <= bus.nonce_limit;
            reportable_q <= 1'b1;
            core_req_q   <= rr_pick(~occ_d, rr_d);
            core_nonce_q <= bus.nonce_base;
            busy_q       <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        DISPATCH: begin
          if (bus.abort) begin
            state_q      <= DRAIN;
            reportable_q <= 1'b0;
            core_req_q   <= '0;
          end else if (reportable_q && (|hit_s)) begin
            state_q       <= DRAIN;
            reportable_q  <= 1'b0;
            core_req_q    <= '0;
            found_q       <= 1'b1;
            found_nonce_q <= hit_res_s;
          end else if (|accept_s) begin
            nonce_q <= nonce_inc_s;
            // The limit itself was just taken: range fully handed out.
            if (nonce_q == limit_q) begin
              state_q    <= DRAIN;
              core_req_q <= '0;
            end else begin
              core_req_q   <= rr_pick(~occ_d, rr_d);
              core_nonce_q <= nonce_inc_s;
            end
          end else if (core_req_q == '0) begin
            // All cores were busy last cycle; retry with freshly freed ones.
            core_req_q   <= rr_pick(~occ_d, rr_d);
            core_nonce_q <= nonce_q;
          end else begin
            core_req_q <= core_req_q;
          end
        end
        DRAIN: begin
          if (occ_q == '0) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            exhausted_q  <= reportable_q & ~bus.abort;
            reportable_q <= 1'b0;
          end else if (bus.abort) begin
            reportable_q <= 1'b0;
          end else if (reportable_q && (|hit_s)) begin
            reportable_q  <= 1'b0;
            found_q       <= 1'b1;
            found_nonce_q <= hit_res_s;
          end else begin
            reportable_q <= reportable_q;
          end
        end
        default: begin
          state_q    <= IDLE;
          core_req_q <= '0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_req    = core_req_q;
  assign bus.core_nonce  = core_nonce_q;
  assign bus.busy        = busy_q;
  assign bus.found       = found_q;
  assign bus.found_nonce = found_nonce_q;
  assign bus.exhausted   = exhausted_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nonce_scheduler
// Directed stimulus for nonce_scheduler with a behavioural hash-core model.
// Expected dispatches and found/exhausted events are queued when a job is
// launched; the core model pops dispatch expectations on every handshake and
// a separate monitor pops event expectations on every found/exhausted pulse.
// -----------------------------------------------------------------------------
module tb_nonce_scheduler;
  localparam int CORES = 2;
  localparam int NW    = 32;

  typedef struct {
    int        core;
    logic [31:0] nonce;
  } disp_t;

  typedef struct {
    logic        is_found;
    logic [31:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  nonce_scheduler_if #(.CORES(CORES), .NONCE_W(NW)) bus ();

  nonce_scheduler #(.CORES(CORES), .NONCE_W(NW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  disp_t       exp_disp[$];
  ev_t         exp_ev[$];
  int          checks    = 0;
  int          errors    = 0;
  int          disp_cnt  = 0;
  logic [CORES-1:0] ack_mask = '1;
  logic [CORES-1:0] hit_en   = '0;
  logic        res_ovr_en = 1'b0;
  logic [31:0] res_ovr[CORES];
  int          lat[CORES];
  int          tmr[CORES];
  logic [31:0] res[CORES];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_disp(input int c, input logic [31:0] n);
    disp_t d;
    d.core  = c;
    d.nonce = n;
    exp_disp.push_back(d);
  endtask

  task automatic push_ev(input logic f, input logic [31:0] v);
    ev_t e;
    e.is_found = f;
    e.val      = v;
    exp_ev.push_back(e);
  endtask

  // Hash-core model plus dispatch scoreboard, evaluated mid-cycle.
  initial begin
    logic [CORES-1:0] done_v, hit_v, ack_v, oh;
    disp_t d;
    bus.core_ack    = '0;
    bus.core_done   = '0;
    bus.core_hit    = '0;
    bus.core_result = '0;
    for (int i = 0; i < CORES; i++) begin
      tmr[i] = 0;
      res[i] = '0;
    end
    forever begin
      @(negedge clk);
      done_v = '0;
      hit_v  = '0;
      for (int i = 0; i < CORES; i++) begin
        if (tmr[i] > 0) begin
          tmr[i]--;
          if (tmr[i] == 0) begin
            done_v[i] = 1'b1;
            hit_v[i]  = hit_en[i];
          end
        end
      end
      chk("req_onehot0", {63'd0, $onehot0(bus.core_req)}, 64'd1);
      ack_v = bus.core_req & ack_mask;
      if (ack_v != '0) begin
        disp_cnt++;
        if (exp_disp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dispatch: unexpected core_req=%b nonce=0x%0h", bus.core_req, bus.core_nonce);
        end else begin
          d  = exp_disp.pop_front();
          oh = '0;
          oh[d.core] = 1'b1;
          chk("dispatch_core", bus.core_req, oh);
          chk("dispatch_nonce", bus.core_nonce, d.nonce);
        end
        for (int i = 0; i < CORES; i++) begin
          if (ack_v[i]) begin
            tmr[i] = lat[i];
            res[i] = res_ovr_en ? res_ovr[i] : bus.core_nonce;
          end
        end
      end
      bus.core_ack  = ack_v;
      bus.core_done = done_v;
      bus.core_hit  = hit_v;
      for (int i = 0; i < CORES; i++) bus.core_result[i*NW +: NW] = res[i];
    end
  end

  // Found/exhausted monitor.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (bus.found === 1'b1) begin
        if (exp_ev.size() == 0 || !exp_ev[0].is_found) begin
          checks++;
          errors++;
          $display("FAIL found_pulse: unexpected found nonce=0x%0h", bus.found_nonce);
        end else begin
          e = exp_ev.pop_front();
          chk("found_nonce", bus.found_nonce, e.val);
        end
      end
      if (bus.exhausted === 1'b1) begin
        if (exp_ev.size() == 0 || exp_ev[0].is_found) begin
          checks++;
          errors++;
          $display("FAIL exhausted_pulse: unexpected exhausted");
        end else begin
          e = exp_ev.pop_front();
          chk("busy_at_exhausted", bus.busy, 64'd0);
        end
      end
    end
  end

  task automatic start_job(input logic [31:0] base, input logic [31:0] limit);
    @(posedge clk); #1;
    bus.nonce_base  = base;
    bus.nonce_limit = limit;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    int active = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_idle"}, bus.busy, 64'd0);
    for (int i = 0; i < CORES; i++) if (tmr[i] != 0) active++;
    chk({name, "_cores_quiet"}, active, 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk({name, "_disp_left"}, exp_disp.size(), 64'd0);
    chk({name, "_ev_left"}, exp_ev.size(), 64'd0);
    exp_disp.delete();
    exp_ev.delete();
  endtask

  task automatic wait_disp(input int target, input string name);
    int n = 0;
    while (disp_cnt < target && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_disp_wait"}, {63'd0, disp_cnt >= target}, 64'd1);
  endtask

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int c;
    int n;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.nonce_base  = '0;
    bus.nonce_limit = '0;
    lat[0] = 5;
    lat[1] = 5;
    res_ovr[0] = 32'h0;
    res_ovr[1] = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_core_req", bus.core_req, 64'd0);
    chk("rst_core_nonce", bus.core_nonce, 64'd0);
    chk("rst_busy", bus.busy, 64'd0);
    chk("rst_found", bus.found, 64'd0);
    chk("rst_found_nonce", bus.found_nonce, 64'd0);
    chk("rst_exhausted", bus.exhausted, 64'd0);

    // Plain range, alternating cores, no hit.
    push_disp(0, 32'h10); push_disp(1, 32'h11);
    push_disp(0, 32'h12); push_disp(1, 32'h13);
    push_ev(1'b0, 32'h0);
    start_job(32'h10, 32'h13);
    wait_idle("t1");

    // Range wrapping through all-ones.
    push_disp(0, 32'hFFFF_FFFE); push_disp(1, 32'hFFFF_FFFF);
    push_disp(0, 32'h0);         push_disp(1, 32'h1);
    push_ev(1'b0, 32'h0);
    start_job(32'hFFFF_FFFE, 32'h1);
    wait_idle("t2");

    // Simultaneous hits: lowest core wins.
    lat[0] = 6; lat[1] = 5;
    hit_en = 2'b11;
    res_ovr_en = 1'b1;
    res_ovr[0] = 32'hAA;
    res_ovr[1] = 32'hBB;
    push_disp(0, 32'hA0); push_disp(1, 32'hA1);
    push_ev(1'b1, 32'hAA);
    start_job(32'hA0, 32'hFF);
    wait_idle("t3");
    chk("t3_found_nonce_held", bus.found_nonce, 64'hAA);
    hit_en = 2'b00;
    res_ovr_en = 1'b0;

    // Abort with core 1 occupied and an offer pending to core 0.
    lat[0] = 3; lat[1] = 30;
    hit_en = 2'b10;
    push_disp(0, 32'h100); push_disp(1, 32'h101);
    c = disp_cnt;
    start_job(32'h100, 32'h1FF);
    wait_disp(c + 2, "t4");
    ack_mask = 2'b00;
    n = 0;
    while (bus.core_req == '0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("t4_req_pending", bus.core_req, 64'h1);
    chk("t4_nonce_pending", bus.core_nonce, 64'h102);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("t4_req_dropped", bus.core_req, 64'd0);
    chk("t4_busy_draining", bus.busy, 64'd1);
    wait_idle("t4");
    ack_mask = 2'b11;
    hit_en = 2'b00;
    lat[0] = 5; lat[1] = 5;

    // Acknowledge withheld for 10 cycles.
    ack_mask = 2'b00;
    push_disp(0, 32'h50); push_disp(1, 32'h51);
    push_ev(1'b0, 32'h0);
    start_job(32'h50, 32'h51);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_req_held", bus.core_req, 64'h1);
      chk("t5_nonce_held", bus.core_nonce, 64'h50);
    end
    @(posedge clk); #1;
    ack_mask = 2'b11;
    wait_idle("t5");

    // Start together with abort stays idle.
    @(posedge clk); #1;
    bus.nonce_base  = 32'h999;
    bus.nonce_limit = 32'h999;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("t6_startabort_busy", bus.busy, 64'd0);
    chk("t6_startabort_req", bus.core_req, 64'd0);

    // Reset mid-dispatch, then replay from a new base.
    push_disp(0, 32'h300); push_disp(1, 32'h301);
    c = disp_cnt;
    start_job(32'h300, 32'h3FF);
    wait_disp(c + 1, "t7");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t7_core_req", bus.core_req, 64'd0);
    chk("t7_core_nonce", bus.core_nonce, 64'd0);
    chk("t7_busy", bus.busy, 64'd0);
    chk("t7_found", bus.found, 64'd0);
    chk("t7_found_nonce", bus.found_nonce, 64'd0);
    chk("t7_exhausted", bus.exhausted, 64'd0);
    repeat (12) begin
      @(posedge clk); #1;
    end
    chk("t7_disp_before_replay", exp_disp.size(), 64'd0);
    exp_disp.delete();
    push_disp(0, 32'h700); push_disp(1, 32'h701);
    push_ev(1'b0, 32'h0);
    start_job(32'h700, 32'h701);
    wait_idle("t7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
